// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states and port ownership.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selector for the fetch and data ports.
// MEM_ARB_RR_EN selects round-robin on conflict; otherwise the data port always wins.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   if_req,
    input  logic   dm_req,
    input  owner_t last_grant,
    output logic   grant_valid,
    output owner_t grant
);

`ifndef MEM_ARB_RR_EN
    // Fixed priority has no use for the history pointer.
    owner_t last_grant_unused;
    assign last_grant_unused = last_grant;
`endif

    always_comb begin
        grant_valid = if_req | dm_req;
        grant       = OWN_IF;
`ifdef MEM_ARB_RR_EN
        if (if_req && dm_req) begin
            grant = (last_grant == OWN_DM) ? OWN_IF : OWN_DM;
        end else if (dm_req) begin
            grant = OWN_DM;
        end
`else
        if (dm_req) begin
            grant = OWN_DM;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-port byte memory with registered read.
// Grant policy is chosen by MEM_ARB_RR_EN (round-robin) or fixed data-port priority when undefined.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ready,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic                  dm_ready,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_load,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    state_t state, state_next;
    owner_t owner, last_grant, grant;
    logic   grant_valid;
    logic   load_grant;

    mem_arb_pick u_pick (
        .if_req      (if_req),
        .dm_req      (dm_req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A new grant can be taken from IDLE or straight out of RESP, giving back-to-back accesses.
    always_comb begin
        state_next = state;
        load_grant = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_next = ISSUE;
                    load_grant = 1'b1;
                end
            end
            ISSUE: state_next = RESP;
            RESP: begin
                if (grant_valid) begin
                    state_next = ISSUE;
                    load_grant = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Memory request registers; mem_load is cleared on leaving ISSUE so it lasts one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= OWN_IF;
            last_grant <= OWN_IF;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_load   <= 1'b0;
        end else if (load_grant) begin
            owner      <= grant;
            last_grant <= grant;
            mem_addr   <= (grant == OWN_DM) ? dm_addr : if_addr;
            mem_wdata  <= (grant == OWN_DM) ? dm_wdata : '0;
            mem_load   <= (grant == OWN_DM) && dm_we;
        end else if (state == ISSUE) begin
            mem_load   <= 1'b0;
        end
    end

    assign if_ready = (state == RESP) && (owner == OWN_IF);
    assign dm_ready = (state == RESP) && (owner == OWN_DM);
    assign if_rdata = mem_rdata;
    assign dm_rdata = mem_rdata;
    assign busy     = (state != IDLE);

endmodule
